// File: rtl/rr_arbiter_pkg.sv
// Shared types and mode constants for the N-requester grant arbiter.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MODE_ROUND_ROBIN = 1;
    localparam int RR_MODE_FIXED       = 0;

endpackage

// File: rtl/rr_arbiter_fsm_pick.sv
// Combinational winner search: round-robin after last_idx, or lowest index,
// over the requests not masked by exclude.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int RR_MODE = RR_MODE_ROUND_ROBIN,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] exclude,
    input  logic [IDX_W-1:0] last_idx,
    output logic             found,
    output logic [IDX_W-1:0] win_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [N_REQ-1:0] cand;
    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        cand    = req & ~exclude;
        found   = |cand;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            if (RR_MODE == RR_MODE_ROUND_ROBIN) begin
                sum = {1'b0, last_idx} + SUM_W'(off);
                if (sum >= SUM_W'(N_REQ)) begin
                    sum = sum - SUM_W'(N_REQ);
                end
            end else begin
                sum = SUM_W'(off - 1);
            end
            idx = sum[IDX_W-1:0];
            if (cand[idx]) begin
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_fsm.sv
// N-requester grant arbiter with round-robin or fixed priority, bounded hold
// time with lock override, and direct owner-to-owner handover.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any request
// GRANT | gnt_idx owns the resource; release, preempt or keep each cycle
module rr_arbiter_fsm
    import rr_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    localparam int IDX_W   = $clog2(N_REQ),
    parameter int RR_MODE  = RR_MODE_ROUND_ROBIN,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             lock,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t        state, next_state;
    logic [HOLD_W-1:0] hold_cnt, next_hold;
    logic [IDX_W-1:0]  last_idx, next_last;
    logic [N_REQ-1:0]  next_gnt, pick_exclude;
    logic [IDX_W-1:0]  next_idx, pick_idx;
    logic              next_preempt, pick_found;

    // In GRANT gnt is exactly onehot(owner), so it doubles as the exclude mask.
    assign pick_exclude = (state == GRANT) ? gnt : '0;

    rr_pick #(
        .N_REQ   (N_REQ),
        .RR_MODE (RR_MODE)
    ) u_pick (
        .req      (req),
        .exclude  (pick_exclude),
        .last_idx (last_idx),
        .found    (pick_found),
        .win_idx  (pick_idx)
    );

    always_comb begin
        next_state   = state;
        next_gnt     = gnt;
        next_idx     = gnt_idx;
        next_hold    = hold_cnt;
        next_last    = last_idx;
        next_preempt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    next_state         = GRANT;
                    next_gnt           = '0;
                    next_gnt[pick_idx] = 1'b1;
                    next_idx           = pick_idx;
                    next_hold          = '0;
                    next_last          = pick_idx;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    if (pick_found) begin
                        next_gnt           = '0;
                        next_gnt[pick_idx] = 1'b1;
                        next_idx           = pick_idx;
                        next_last          = pick_idx;
                    end else begin
                        next_state = IDLE;
                        next_gnt   = '0;
                        next_idx   = '0;
                    end
                    next_hold = '0;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && !lock && pick_found) begin
                    next_gnt           = '0;
                    next_gnt[pick_idx] = 1'b1;
                    next_idx           = pick_idx;
                    next_last          = pick_idx;
                    next_hold          = '0;
                    next_preempt       = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    next_hold = hold_cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                next_gnt   = '0;
                next_idx   = '0;
                next_hold  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last_idx  <= IDX_W'(N_REQ - 1);
        end else begin
            state     <= next_state;
            gnt       <= next_gnt;
            gnt_valid <= |next_gnt;
            gnt_idx   <= next_idx;
            preempt   <= next_preempt;
            hold_cnt  <= next_hold;
            last_idx  <= next_last;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm: a round-robin/MAX_HOLD=8 instance and a
// fixed-priority/unlimited-hold instance share stimulus, each checked
// against its own behavioural model.
module tb_rr_arbiter_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       lock;

    logic [3:0] gnt_a, gnt_b;
    logic       gnt_valid_a, gnt_valid_b;
    logic [1:0] gnt_idx_a, gnt_idx_b;
    logic       preempt_a, preempt_b;

    int checks = 0;
    int errors = 0;

    int m_owner [2];
    int m_hold  [2];
    int m_last  [2];
    int m_pre   [2];
    int m_rr    [2] = '{1, 0};
    int m_max   [2] = '{8, 0};

    always #5 clock = ~clock;

    rr_arbiter_fsm #(.N_REQ(4), .RR_MODE(1), .MAX_HOLD(8), .HOLD_W(8)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt_a),
        .gnt_valid (gnt_valid_a),
        .gnt_idx   (gnt_idx_a),
        .preempt   (preempt_a)
    );

    rr_arbiter_fsm #(.N_REQ(4), .RR_MODE(0), .MAX_HOLD(0), .HOLD_W(8)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt_b),
        .gnt_valid (gnt_valid_b),
        .gnt_idx   (gnt_idx_b),
        .preempt   (preempt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner: nearest requester after last (rotating) or lowest index, skipping excl.
    function automatic int pick(input int m, input logic [3:0] r, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_rr[m] != 0) ? (m_last[m] + k) % 4 : k - 1;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m, input logic [3:0] r, input logic l, input logic rs);
        int w;
        m_pre[m] = 0;
        if (rs) begin
            m_owner[m] = -1;
            m_hold[m]  = 0;
            m_last[m]  = 3;
        end else if (m_owner[m] < 0) begin
            w = pick(m, r, -1);
            if (w >= 0) begin
                m_owner[m] = w;
                m_hold[m]  = 0;
                m_last[m]  = w;
            end
        end else begin
            w = pick(m, r, m_owner[m]);
            if (!r[m_owner[m]]) begin
                m_owner[m] = w;
                m_hold[m]  = 0;
                if (w >= 0) m_last[m] = w;
            end else if (m_max[m] != 0 && m_hold[m] == m_max[m] - 1 && !l && w >= 0) begin
                m_owner[m] = w;
                m_hold[m]  = 0;
                m_last[m]  = w;
                m_pre[m]   = 1;
            end else if (m_max[m] != 0 && m_hold[m] < m_max[m] - 1) begin
                m_hold[m]++;
            end
        end
    endtask

    task automatic check_dut(input int m, input logic [3:0] g, input logic v,
                             input logic [1:0] idx, input logic p, input logic [3:0] r, input logic rs);
        int exp_g;
        string n;
        n = (m == 0) ? "rr" : "fix";
        exp_g = (m_owner[m] < 0) ? 0 : (1 << m_owner[m]);
        check({n, "_gnt"},       32'(g),   32'(exp_g));
        check({n, "_gnt_valid"}, 32'(v),   32'(m_owner[m] >= 0));
        check({n, "_gnt_idx"},   32'(idx), 32'((m_owner[m] < 0) ? 0 : m_owner[m]));
        check({n, "_preempt"},   32'(p),   32'(m_pre[m]));
        check({n, "_onehot0"},   32'($onehot0(g)), 32'(1));
        if (!rs) check({n, "_granted_without_req"}, 32'(g & ~r), 32'(0));
    endtask

    task automatic step(input logic [3:0] r, input logic l, input logic rs);
        req   = r;
        lock  = l;
        reset = rs;
        @(posedge clock);
        model_step(0, r, l, rs);
        model_step(1, r, l, rs);
        #1;
        check_dut(0, gnt_a, gnt_valid_a, gnt_idx_a, preempt_a, r, rs);
        check_dut(1, gnt_b, gnt_valid_b, gnt_idx_b, preempt_b, r, rs);
        @(negedge clock);
    endtask

    initial begin
        req   = '0;
        lock  = 1'b0;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_hold[m]  = 0;
            m_last[m]  = 3;
            m_pre[m]   = 0;
        end
        @(negedge clock);

        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);

        // All four requesting: eight cycles each in rotation, preempt at each switch.
        for (int k = 0; k < 33; k++) begin
            step(4'b1111, 1'b0, 1'b0);
            check("rr_rotation_idx", 32'(gnt_idx_a), 32'((k / 8) % 4));
            check("rr_rotation_preempt", 32'(preempt_a), 32'(k > 0 && k % 8 == 0));
            check("fix_stays_0", 32'(gnt_b), 32'(1));
        end
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b0, 1'b0);
            check("single_req0_gnt", 32'(gnt_a), 32'(1));
        end
        step(4'b0000, 1'b0, 1'b0);
        check("release_to_idle", 32'(gnt_valid_a), 32'(0));

        // Owner 1 with lock held while requester 2 waits.
        step(4'b0010, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(4'b0110, 1'b1, 1'b0);
            check("lock_keeps_owner", 32'(gnt_a), 32'(4'b0010));
        end
        step(4'b0110, 1'b0, 1'b0);
        check("lock_drop_handover", 32'(gnt_a), 32'(4'b0100));
        check("lock_drop_preempt", 32'(preempt_a), 32'(1));
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 20; k++) begin
            step(4'b1010, 1'b0, 1'b0);
        end
        check("fix_unlimited_hold", 32'(gnt_b), 32'(4'b0010));
        step(4'b1000, 1'b0, 1'b0);
        check("fix_direct_handover", 32'(gnt_b), 32'(4'b1000));
        step(4'b0000, 1'b0, 1'b0);

        // Owner 2 then reset mid-grant with everyone requesting.
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1);
        check("reset_clears_gnt", 32'(gnt_a), 32'(0));
        step(4'b1111, 1'b0, 1'b0);
        check("after_reset_first_is_0", 32'(gnt_a), 32'(1));
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 50; k++) begin
            step(4'b1000, 1'b0, 1'b0);
            check("single_req3_no_preempt", 32'(preempt_a), 32'(0));
        end
        check("single_req3_gnt", 32'(gnt_a), 32'(4'b1000));
        step(4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 400; k++) begin
            logic [3:0] r;
            r = 4'($urandom);
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
Parametrised N-requester grant arbiter. It is the successor to the two-requester IDLE/GNT0/GNT1 grant state machine, generalised to N_REQ channels.
- Selectable round-robin or fixed-priority mode.
- Bounded hold time, with a lock override.
- Direct grant handover between requesters, with no idle gap.
It sits between shared-resource clients and the resource owner (bus, memory port).

Parameters:
N_REQ, 4, number of requesters (2..16)
IDX_W, $clog2(N_REQ), width of grant index (derived, not overridden)
RR_MODE, 1, 1 = round-robin rotation; 0 = fixed priority (index 0 highest)
MAX_HOLD, 8, max consecutive grant cycles while another requester waits; 0 = unlimited
HOLD_W, 8, width of hold counter (must hold MAX_HOLD)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  request vector, level-sensitive, bit i = requester i
lock  in  1  current owner asks to extend grant past MAX_HOLD (ignored in IDLE)
gnt  out  N_REQ  registered one-hot grant; all-zero when idle
gnt_valid  out  1  registered, equals |gnt
gnt_idx  out  IDX_W  registered index of granted requester; 0 when idle
preempt  out  1  one-cycle pulse: grant was taken from an owner whose req was still high

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - Outputs: gnt=0, gnt_valid=0, gnt_idx=0, preempt=0.
  - Internal: state=IDLE, hold_cnt=0, last_idx=N_REQ-1, so requester 0 wins first in RR mode.
- Reset mid-grant: takes effect at the next edge and overrides all other events.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner W. On the next edge: gnt=onehot(W), gnt_idx=W, state=GRANT, hold_cnt=0.
  - Latency from req to gnt is 1 cycle.
- Winner selection (combinational from req and last_idx):
  - RR_MODE=1: first set bit searching last_idx+1, last_idx+2, ... with wrap modulo N_REQ.
  - RR_MODE=0: lowest set index.
- GRANT, owner O = gnt_idx. Evaluate in this order:
  1. Release: req[O]==0.
     - If other requests exist (req & ~onehot(O) != 0): hand over directly to the next winner on the same edge (no idle cycle), hold_cnt=0, preempt=0.
     - Else go to IDLE with gnt=0.
  2. Preempt: req[O]==1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, lock==0, and another request pending.
     - Hand over to the next winner with O excluded from the search.
     - preempt=1 for one cycle. hold_cnt=0.
  3. Otherwise keep O.
     - hold_cnt increments, saturating at MAX_HOLD-1.
     - If no other request is pending, the owner keeps the grant indefinitely and the counter stays saturated.
     - With lock==1, the owner keeps the grant and the counter stays saturated. When lock drops with others waiting, preemption happens on that edge.
- last_idx updates to the new winner on every grant or handover. It is unchanged on return to IDLE.
- In RR_MODE=0, preemption hands to the lowest-index other requester.
- Simultaneous release and new request: a requester whose req rises in the same cycle as the owner's drop is eligible for the handover.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_idx matches gnt.
  - No requester is granted while its req was 0 at the deciding edge.

Decomposition:
- Package rr_arbiter_pkg holds:
  - the state enum (IDLE, GRANT);
  - mode constants RR_MODE_ROUND_ROBIN=1 and RR_MODE_FIXED=0.
- One sub-module, rr_pick:
  - purely combinational; parameters N_REQ and RR_MODE;
  - inputs: req vector, exclude mask, last_idx;
  - outputs: found, win_idx.
  - Instantiated once. The FSM supplies exclude = onehot(O) for handover and preemption, and 0 otherwise.

Test Plan:
- N_REQ=4, RR: from reset assert req=4'b1111 and hold it → grants 0,0,...(8 cycles),1×8,2×8,3×8,0; preempt pulses at each switch; no idle gap.
- req=4'b0001 for 3 cycles then 0 → gnt=0001 on cycle 1 through cycle 3, gnt=0 one cycle after req drops, gnt_valid follows.
- Owner 1 granted, req=4'b0110, lock=1 for 20 cycles → gnt stays 0010, preempt=0. lock drops → next edge gnt=0100, preempt=1.
- RR_MODE=0, req=4'b1010 constant, MAX_HOLD=0 → gnt=0010 forever. Then req[1] drops → next edge gnt=1000 directly.
- Mid-grant reset: owner 2 granted, reset for 1 cycle with req=1111 → gnt=0 during the reset cycle. Next grant is requester 0 (last_idx reset).
- Single requester 3 held for 50 cycles with MAX_HOLD=8 → gnt=1000 continuously, preempt never asserted, hold counter saturated.
